pio_edge_capture_in: RTL and testbench

- Avalon-MM slave input port: the read-side counterpart of the existing 8-bit output PIO slaves in the SoC system.
- Samples an external input bus through a 2-flop synchronizer and exposes it as readable data.
- Latches per-bit edges into an edge-capture register and raises a maskable level interrupt towards the HPS.
- Sits on the lightweight HPS-to-FPGA bridge beside the output PIOs.

---
 rtl/pio_pkg.sv | 16 +
 rtl/pio_sync_edge.sv | 48 ++++
 rtl/pio_edge_capture_in.sv | 91 +++++++++
 tb/tb_pio_edge_capture_in.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO slave family: register addresses and the
// edge-type encoding used by the input-capture PIO.
package pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/pio_sync_edge.sv
// Synchronizer chain for the asynchronous PIO inputs.
// Also holds the previous-sample register and produces the per-bit edge-detect vector.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] detect
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  // prev_in restarts from 0 together with the chain, so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_in <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_in <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev_in;
  assign fall    = ~sync_in & prev_in;

  generate
    if (EDGE_TYPE == int'(EDGE_RISE)) begin : g_rise
      assign detect = rise;
    end else if (EDGE_TYPE == int'(EDGE_FALL)) begin : g_fall
      assign detect = fall;
    end else begin : g_any
      assign detect = rise | fall;
    end
  endgenerate

endmodule

// File: rtl/pio_edge_capture_in.sv
// Avalon-MM input PIO with edge capture and a maskable level interrupt.
// Optional macro PIO_EDGE_BIT_CLEAR_EN: per-bit write-1-to-clear of edge_capture (otherwise any write clears all).
module pio_edge_capture_in
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] edge_next;
  logic [WIDTH-1:0] clear;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             rd_en;
  logic             unused_wdata;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .sync_in (sync_in),
    .detect  (detect)
  );

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & ~read_n;
  assign unused_wdata = &{1'b0, writedata};

  // OR-ing detect in after the clear lets a fresh edge survive a same-cycle clear
  always_comb begin
    mask_next = irq_mask;
    clear     = '0;
    if (wr_en && (address == PIO_ADDR_IRQMASK)) mask_next = writedata[WIDTH-1:0];
    if (wr_en && (address == PIO_ADDR_EDGE)) begin
`ifdef PIO_EDGE_BIT_CLEAR_EN
      clear = writedata[WIDTH-1:0];
`else
      clear = '1;
`endif
    end
    edge_next = (edge_capture & ~clear) | detect;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_in;
      PIO_ADDR_DIR:     rd_mux = '0;
      PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      PIO_ADDR_EDGE:    rd_mux[WIDTH-1:0] = edge_capture;
      default:          rd_mux = '0;
    endcase
  end

  // Reads sample the pre-write register state, so read+write returns the old value
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata     <= '0;
      irq          <= 1'b0;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      irq_mask     <= mask_next;
      edge_capture <= edge_next;
      irq          <= |(edge_next & mask_next);
      if (rd_en) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pio_edge_capture_in.sv
// Scoreboard bench for pio_edge_capture_in: one rising-edge instance and one any-edge instance
// share the bus; each read pushes the expected readdata/irq, and a monitor checks the response.
module tb_pio_edge_capture_in;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [31:0] rd0;
  logic [31:0] rd1;
  logic        irq0;
  logic        irq1;

  typedef struct {
    string       name;
    int          inst;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

`ifdef PIO_EDGE_BIT_CLEAR_EN
  localparam logic [31:0] EXP_PARTIAL_CLR = 32'h01;
`else
  localparam logic [31:0] EXP_PARTIAL_CLR = 32'h00;
`endif

  always #5 clk = ~clk;

  pio_edge_capture_in #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .readdata(rd0), .in_port(in_a), .irq(irq0)
  );

  pio_edge_capture_in #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .readdata(rd1), .in_port(in_b), .irq(irq1)
  );

  // Monitor: a read strobe seen at a rising edge is answered by that edge
  initial begin : monitor
    bit          pend;
    exp_t        e;
    logic [31:0] act_rd;
    logic        act_irq;
    forever begin
      @(posedge clk);
      pend = chipselect && !read_n;
      @(negedge clk);
      if (pend) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_read: got response with empty scoreboard, want none");
        end else begin
          e       = sb.pop_front();
          act_rd  = (e.inst == 0) ? rd0 : rd1;
          act_irq = (e.inst == 0) ? irq0 : irq1;
          n_total++;
          if (act_rd === e.rd) n_pass++;
          else $display("FAIL %s readdata: got %h want %h", e.name, act_rd, e.rd);
          n_total++;
          if (act_irq === e.irq) n_pass++;
          else $display("FAIL %s irq: got %b want %b", e.name, act_irq, e.irq);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want normal end");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp_rd, input logic exp_irq,
                    input int inst, input string nm);
    sb.push_back('{name: nm, inst: inst, rd: exp_rd, irq: exp_irq});
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(posedge clk);
    #1;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp_rd,
                    input logic exp_irq, input int inst, input string nm);
    sb.push_back('{name: nm, inst: inst, rd: exp_rd, irq: exp_irq});
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  initial begin : stim
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    writedata = '0; in_a = 8'h00; in_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    rd(2'd0, 32'h0, 1'b0, 0, "rst_data");
    rd(2'd2, 32'h0, 1'b0, 0, "rst_mask");
    rd(2'd3, 32'h0, 1'b0, 0, "rst_edge");

    // Rising-edge capture, synchronizer latency
    in_a = 8'h05;
    idle(1);
    rd(2'd0, 32'h00, 1'b0, 0, "sync_not_yet");
    rd(2'd0, 32'h05, 1'b0, 0, "sync_data");
    rd(2'd3, 32'h05, 1'b0, 0, "edge_0x05");
    wr(2'd2, 32'h04);
    rd(2'd2, 32'h04, 1'b1, 0, "mask_irq_on");
    wr(2'd3, 32'h04);
    rd(2'd3, EXP_PARTIAL_CLR, 1'b0, 0, "clr_0x04");
    wr(2'd3, 32'hFF);
    rd(2'd3, 32'h00, 1'b0, 0, "clr_all");

    // Clear write in the same cycle as a new bit-0 rising edge
    in_a = 8'h04;
    idle(3);
    in_a = 8'h05;
    idle(2);
    wr(2'd3, 32'h01);
    rd(2'd3, 32'h01, 1'b0, 0, "detect_wins");

    // Read and write strobes together, ignored writes, upper bits
    rw(2'd2, 32'h01, 32'h04, 1'b1, 0, "rw_old_value");
    rd(2'd2, 32'h01, 1'b1, 0, "rw_new_value");
    wr(2'd0, 32'hAA);
    rd(2'd0, 32'h05, 1'b1, 0, "data_ro");
    wr(2'd1, 32'hFF);
    rd(2'd1, 32'h00, 1'b1, 0, "reserved");
    wr(2'd2, 32'hFFFFFF03);
    rd(2'd2, 32'h03, 1'b1, 0, "mask_upper");
    wr(2'd3, 32'hFF);
    rd(2'd3, 32'h00, 1'b0, 0, "clr_all2");

    // Any-edge instance: pulse bit 7, clear between rise and fall
    wr(2'd2, 32'h80);
    in_b = 8'h80;
    idle(3);
    in_b = 8'h00;
    rd(2'd3, 32'h80, 1'b1, 1, "any_rise");
    wr(2'd3, 32'hFF);
    rd(2'd3, 32'h00, 1'b1, 1, "any_cleared");
    rd(2'd3, 32'h80, 1'b1, 1, "any_fall");
    wr(2'd3, 32'hFF);
    rd(2'd3, 32'h00, 1'b0, 1, "any_clr");

    // Reset while irq is high
    wr(2'd2, 32'hFF);
    in_a = 8'hFF;
    idle(3);
    rd(2'd3, 32'hFA, 1'b1, 0, "pre_reset");
    reset = 1'b1;
    rd(2'd3, 32'h00, 1'b0, 0, "in_reset");
    reset = 1'b0;
    idle(3);
    rd(2'd3, 32'hFF, 1'b0, 0, "post_reset_edge");
    rd(2'd2, 32'h00, 1'b0, 0, "post_reset_mask");
    rd(2'd0, 32'hFF, 1'b0, 0, "post_reset_data");

    idle(3);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending responses, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
